// File: rtl/sr_serial_ctrl.sv
// rtl/sr_serial_ctrl.sv - load/shift/capture sequencer driving an external shift register as a serial engine
module sr_serial_ctrl #(
  parameter int BITS      = 8,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [BITS-1:0] rx_data,
  output logic            rx_valid,
  output logic            busy,
  output logic            sck,
  output logic            cs_n,
  output logic [1:0]      sr_mode,
  output logic [BITS-1:0] sr_load_data,
  input  logic [BITS-1:0] sr_data
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(BITS + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS - 1);
  localparam logic [1:0]    SHIFT_MODE = MSB_FIRST ? 2'b10 : 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state;
  logic [BITS-1:0] word;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;

  // Sequencer: accept a word, load it, shift BITS times at the divided rate, capture the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      word    <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            word  <= tx_data;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state <= S_DONE;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // The final shift landed on the edge entering DONE, so sr_data is settled here
          rx_data <= sr_data;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from registered state and counters only
  always_comb begin
    tx_ready = 1'b0;
    busy     = 1'b1;
    cs_n     = 1'b0;
    sck      = 1'b0;
    sr_mode  = 2'b00;
    rx_valid = 1'b0;
    case (state)
      S_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        cs_n     = 1'b1;
      end
      S_LOAD: sr_mode = 2'b11;
      S_SHIFT: begin
        sck = (div_cnt >= DIV_HALF);
        if (div_cnt == DIV_LAST) begin
          sr_mode = SHIFT_MODE;
        end
      end
      S_DONE: rx_valid = 1'b1;
      default: begin
        tx_ready = 1'b0;
      end
    endcase
  end

  assign sr_load_data = word;

endmodule

// File: tb/tb_sr_serial_ctrl.sv
// tb/tb_sr_serial_ctrl.sv - randomized and directed checks of sr_serial_ctrl against a behavioural model
module tb_sr_serial_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0][7:0] tx_data;
  logic [2:0]      tx_valid;
  wire  [2:0]      tx_ready;
  wire  [2:0][7:0] rx_data;
  wire  [2:0]      rx_valid;
  wire  [2:0]      busy;
  wire  [2:0]      sck;
  wire  [2:0]      cs_n;
  wire  [2:0][1:0] sr_mode;
  wire  [2:0][7:0] sr_load;
  logic [2:0][7:0] sr_q;
  logic [2:0]      loop_en;
  logic            ext_bit;

  int tests;
  int fails;

  // Instance 0: DIV=4 MSB first; instance 1: DIV=4 LSB first; instance 2: DIV=2 MSB first
  sr_serial_ctrl #(.BITS(8), .DIV(4), .MSB_FIRST(1'b1)) u_msb4 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .busy(busy[0]), .sck(sck[0]), .cs_n(cs_n[0]),
    .sr_mode(sr_mode[0]), .sr_load_data(sr_load[0]), .sr_data(sr_q[0])
  );

  sr_serial_ctrl #(.BITS(8), .DIV(4), .MSB_FIRST(1'b0)) u_lsb4 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .busy(busy[1]), .sck(sck[1]), .cs_n(cs_n[1]),
    .sr_mode(sr_mode[1]), .sr_load_data(sr_load[1]), .sr_data(sr_q[1])
  );

  sr_serial_ctrl #(.BITS(8), .DIV(2), .MSB_FIRST(1'b1)) u_msb2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .rx_data(rx_data[2]), .rx_valid(rx_valid[2]), .busy(busy[2]), .sck(sck[2]), .cs_n(cs_n[2]),
    .sr_mode(sr_mode[2]), .sr_load_data(sr_load[2]), .sr_data(sr_q[2])
  );

  // External shift registers: loopback ties bit_out to bit_in, otherwise bit_in = ext_bit
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      case (sr_mode[k])
        2'b11: sr_q[k] <= sr_load[k];
        2'b10: sr_q[k] <= {sr_q[k][6:0], loop_en[k] ? sr_q[k][7] : ext_bit};
        2'b01: sr_q[k] <= {loop_en[k] ? sr_q[k][0] : ext_bit, sr_q[k][7:1]};
        default: sr_q[k] <= sr_q[k];
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic int div_of(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  function automatic logic [1:0] dir_of(input int i);
    return (i == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame on instance i; at cycle nc the bench drives tx_valid=nv / tx_data=nw
  task automatic xfer(input int i, input logic [7:0] w, input int nc, input logic nv,
                      input logic [7:0] nw, input logic [7:0] exp_rx, input int exp_wait);
    int n;
    int d;
    int len;
    int loads;
    int sck_rise;
    int frame_err;
    int pos_err;
    int rxv_cnt;
    int rxv_cycle;
    int shifts[$];
    logic prev_sck;
    logic exp_sck;
    d = div_of(i);
    len = 2 + 8 * d;
    tx_data[i] = w;
    tx_valid[i] = 1'b1;
    n = 0;
    while (tx_ready[i] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_wait < 0) check($sformatf("inst%0d accept_in_time", i), 32'(n < 100), 32'd1);
    else check($sformatf("inst%0d accept_wait", i), 32'(n), 32'(exp_wait));
    loads = 0; sck_rise = 0; frame_err = 0; pos_err = 0; rxv_cnt = 0; rxv_cycle = -1;
    prev_sck = 1'b0;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid[i] = 1'b0;
      if (c == nc) begin
        tx_data[i] = nw;
        tx_valid[i] = nv;
      end
      if (sr_mode[i] === 2'b11) begin
        loads++;
        if (c != 1) frame_err++;
      end else if (sr_mode[i] === dir_of(i)) begin
        shifts.push_back(c);
      end else if (sr_mode[i] !== 2'b00) begin
        frame_err++;
      end
      exp_sck = (c >= 2 && c <= len - 1) ? (((c - 2) % d) >= d / 2) : 1'b0;
      if (sck[i] !== exp_sck) frame_err++;
      if (sck[i] === 1'b1 && !prev_sck) sck_rise++;
      prev_sck = sck[i];
      if (cs_n[i] !== 1'b0 || busy[i] !== 1'b1 || tx_ready[i] !== 1'b0) frame_err++;
      if (rx_valid[i] === 1'b1) begin
        rxv_cnt++;
        rxv_cycle = c;
      end
    end
    for (int j = 0; j < shifts.size(); j++) begin
      if (shifts[j] != 1 + d * (j + 1)) pos_err++;
    end
    check($sformatf("inst%0d load_pulses", i), 32'(loads), 32'd1);
    check($sformatf("inst%0d shift_pulses", i), 32'(shifts.size()), 32'd8);
    check($sformatf("inst%0d shift_spacing_errs", i), 32'(pos_err), 32'd0);
    check($sformatf("inst%0d sck_pulses", i), 32'(sck_rise), 32'd8);
    check($sformatf("inst%0d framing_errs", i), 32'(frame_err), 32'd0);
    check($sformatf("inst%0d rx_valid_count", i), 32'(rxv_cnt), 32'd1);
    check($sformatf("inst%0d rx_valid_cycle", i), 32'(rxv_cycle), 32'(len));
    @(negedge clk);
    check($sformatf("inst%0d rx_data", i), 32'(rx_data[i]), 32'(exp_rx));
    check($sformatf("inst%0d ready_after", i), 32'(tx_ready[i]), 32'd1);
    check($sformatf("inst%0d cs_n_after", i), 32'(cs_n[i]), 32'd1);
    check($sformatf("inst%0d rx_valid_after", i), 32'(rx_valid[i]), 32'd0);
  endtask

  // Abort a frame on instance 0 with rst at cycle 15
  task automatic reset_mid();
    int n;
    int rxv;
    tx_data[0] = 8'hC3;
    tx_valid[0] = 1'b1;
    n = 0;
    while (tx_ready[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rstmid accept_in_time", 32'(n < 100), 32'd1);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rstmid cs_n", 32'(cs_n[0]), 32'd1);
    check("rstmid sr_mode", 32'(sr_mode[0]), 32'd0);
    check("rstmid tx_ready", 32'(tx_ready[0]), 32'd1);
    check("rstmid busy", 32'(busy[0]), 32'd0);
    check("rstmid sck", 32'(sck[0]), 32'd0);
    rst = 1'b0;
    rxv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rx_valid[0] === 1'b1) rxv++;
    end
    check("rstmid no_rx_valid", 32'(rxv), 32'd0);
    check("rstmid rx_data", 32'(rx_data[0]), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] exp_rx;
    int i;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    tx_valid = '0;
    tx_data = '0;
    loop_en = 3'b111;
    ext_bit = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("inst%0d reset tx_ready", k), 32'(tx_ready[k]), 32'd1);
      check($sformatf("inst%0d reset cs_n", k), 32'(cs_n[k]), 32'd1);
      check($sformatf("inst%0d reset sck", k), 32'(sck[k]), 32'd0);
      check($sformatf("inst%0d reset sr_mode", k), 32'(sr_mode[k]), 32'd0);
      check($sformatf("inst%0d reset rx_valid", k), 32'(rx_valid[k]), 32'd0);
      check($sformatf("inst%0d reset rx_data", k), 32'(rx_data[k]), 32'd0);
      check($sformatf("inst%0d reset busy", k), 32'(busy[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Loopback, MSB first: the word comes back unchanged
    xfer(0, 8'hA5, 1, 1'b0, 8'h00, 8'hA5, -1);

    // External bit_in held 1, LSB first: every bit is replaced by 1
    loop_en[1] = 1'b0;
    ext_bit = 1'b1;
    xfer(1, 8'h00, 1, 1'b0, 8'h00, 8'hFF, -1);

    // Busy rejection: 0x3C offered at cycle 10 is ignored, then accepted immediately after DONE
    w = 8'h3C ^ 8'($urandom_range(1, 255));
    xfer(0, w, 10, 1'b1, 8'h3C, w, -1);
    xfer(0, 8'h3C, 1, 1'b0, 8'h00, 8'h3C, 0);

    // Reset mid-transfer, then a clean frame
    reset_mid();
    xfer(0, 8'h5A, 1, 1'b0, 8'h00, 8'h5A, -1);

    // DIV=2 back-to-back with tx_valid held; tx_data changes right after acceptance
    xfer(2, 8'h81, 1, 1'b1, 8'h7E, 8'h81, -1);
    xfer(2, 8'h7E, 1, 1'b0, 8'h00, 8'h7E, 0);

    // Randomized frames: loopback returns the word, a constant bit_in fills the word with it
    for (int r = 0; r < 8; r++) begin
      i = int'($urandom_range(0, 2));
      w = 8'($urandom);
      if (i == 1) begin
        loop_en[1] = 1'($urandom_range(0, 1));
        ext_bit = 1'($urandom_range(0, 1));
      end
      exp_rx = loop_en[i] ? w : {8{ext_bit}};
      xfer(i, w, 1, 1'b0, 8'h00, exp_rx, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_serial_ctrl.md
Name: sr_serial_ctrl

Overview:
Sequencer for one external shift_register instance (BITS wide) used as a full-duplex serial engine. It accepts a parallel word over a valid/ready handshake and drives the register's mode and DATA_IN inputs to load, then shift BITS times at a divided bit rate. It then captures the register's parallel DATA as the received word. It generates the serial clock and chip-select framing. The serial data pins connect directly to the shift register's bit_in and bit_out, not to this block.

Parameters:
BITS, 8, word width; must match the controlled shift_register.
DIV, 4, system clocks per bit period; even, >= 2.
MSB_FIRST, 1, 1 = shift left (sr_mode 10), 0 = shift right (sr_mode 01).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
tx_data  in  BITS  word to transmit.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  controller can accept a word.
rx_data  out  BITS  last received word.
rx_valid  out  1  one-cycle pulse: rx_data updated.
busy  out  1  transfer in progress.
sck  out  1  serial clock.
cs_n  out  1  active-low frame select.
sr_mode  out  2  to shift_register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
sr_load_data  out  BITS  to shift_register DATA_IN.
sr_data  in  BITS  from shift_register DATA.

Behaviour:
- Shift register contract: 10 = shift toward MSB, bit_in enters LSB, bit_out = MSB. 01 = shift toward LSB, bit_in enters MSB, bit_out = LSB. Each takes effect on the clk edge where the mode is applied.
- FSM states: IDLE, LOAD, SHIFT, DONE. Registers: state, word latch, div_cnt (0..DIV-1), bit_cnt (0..BITS), rx_data.
- IDLE:
  - tx_ready=1, busy=0, cs_n=1, sck=0, sr_mode=00.
  - On tx_valid && tx_ready: latch tx_data and go to LOAD.
- LOAD (1 cycle):
  - sr_mode=11, sr_load_data = latched word.
  - cs_n=0, busy=1.
  - Clear div_cnt and bit_cnt, then go to SHIFT.
- SHIFT:
  - div_cnt increments each cycle and wraps at DIV-1.
  - sck = 1 while div_cnt >= DIV/2, else 0.
  - sr_mode = shift direction only in the cycle where div_cnt == DIV-1, else 00. That same edge increments bit_cnt.
  - When the shift with bit_cnt == BITS-1 completes, go to DONE.
- DONE (1 cycle):
  - rx_data <= sr_data and rx_valid = 1; cs_n stays 0 this cycle.
  - Next state is IDLE.
- Combinational decode: sr_mode, sck, cs_n, tx_ready and busy decode from registered state and counters only; no input feeds any output combinationally.
- sr_load_data equals the latched word in every state; it is only consumed while sr_mode = 11.
- Timing (handshake edge = cycle 0): LOAD in cycle 1, SHIFT in cycles 2..1+BITS*DIV, DONE in cycle 2+BITS*DIV, tx_ready = 1 from cycle 3+BITS*DIV. Defaults: DONE at cycle 34, next accept at cycle 35.
- Reset values: all outputs 0 except cs_n=1 and tx_ready=1; sr_mode=00, rx_data=0, rx_valid=0.
- tx_valid while busy: ignored (tx_ready=0). The word is not latched and not queued.
- tx_data changes after acceptance: no effect, because the latched copy is used.
- rst asserted mid-transfer: next edge returns to IDLE with reset outputs. No rx_valid is produced, and rx_data keeps its reset value of 0.
- The bit_cnt and div_cnt wrap conditions must hold for DIV = 2 (sck toggles every cycle).

Test Plan:
- Reset: hold rst 3 cycles -> tx_ready=1, cs_n=1, sck=0, sr_mode=00, rx_valid=0, rx_data=0.
- Loopback: shift_register bit_out tied to bit_in, send 0xA5 with MSB_FIRST=1, DIV=4 -> sr_mode=11 in cycle 1; exactly 8 cycles with sr_mode=10, spaced 4 apart; rx_valid pulse in cycle 34; rx_data=0xA5; 8 sck pulses.
- External input: bit_in held 1, send 0x00, MSB_FIRST=0 -> only sr_mode=01 pulses; rx_data=0xFF.
- Busy rejection: second tx_valid with 0x3C in cycle 10 -> tx_ready=0 and it is not accepted; rx_data reflects the first word only. Re-presenting 0x3C at cycle 35 is accepted.
- Reset mid-transfer: rst at cycle 15 -> cs_n=1 and sr_mode=00 on the next edge; no rx_valid; a new 0x5A then completes normally.
- Minimum divider, DIV=2, back-to-back 0x81 then 0x7E held on tx_valid -> each frame is 2+16 cycles plus DONE; rx_data sequence 0x81, 0x7E in loopback.
